// File: rtl/regfile_dump.sv
// regfile_dump: streams all 32 registers of a register file as valid/ready beats.
// Optional trailing XOR-checksum beat enabled by defining REGFILE_DUMP_CHECKSUM_EN.
module regfile_dump (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  dump_read_idx,
  input  logic [31:0] dump_read_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_idx,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done
);
`ifdef REGFILE_DUMP_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, SEND, CSUM} state_t;
  logic [31:0] acc_q;
`else
  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
`endif
  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [4:0]  idx_q;
  logic [31:0] data_q;
  logic        valid_q;
  logic        last_q;
  logic        busy_q;
  logic        done_q;
  assign dump_read_idx = cnt_q;
  assign out_valid     = valid_q;
  assign out_idx       = idx_q;
  assign out_data      = data_q;
  assign out_last      = last_q;
  assign busy          = busy_q;
  assign done          = done_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      acc_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // a start coinciding with the done pulse is dropped, not deferred
          if (start && !done_q) begin
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= LOAD;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            acc_q   <= '0;
`endif
          end
        end
        LOAD: begin
          data_q  <= dump_read_data;
          idx_q   <= cnt_q;
          valid_q <= 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          last_q  <= 1'b0;
          acc_q   <= acc_q ^ dump_read_data;
`else
          last_q  <= (cnt_q == 5'd31);
`endif
          state_q <= SEND;
        end
        SEND: begin
          if (valid_q && out_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (cnt_q != 5'd31) begin
              cnt_q   <= cnt_q + 5'd1;
              state_q <= LOAD;
            end else begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
              state_q <= CSUM;
`else
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
`endif
            end
          end
        end
`ifdef REGFILE_DUMP_CHECKSUM_EN
        CSUM: begin
          if (!valid_q) begin
            valid_q <= 1'b1;
            data_q  <= acc_q;
            idx_q   <= 5'd31;
            last_q  <= 1'b1;
          end else if (out_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: directed + randomized checks of regfile_dump against a beat-list model.
module tb_regfile_dump;
  logic        clock = 1'b0;
  logic        reset, start, out_ready;
  logic [4:0]  dump_read_idx, out_idx;
  logic [31:0] dump_read_data, out_data;
  logic        out_valid, out_last, busy, done;
  logic [31:0] regs [32];
  int total = 0, bad = 0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif
  logic [31:0] last_data;

  regfile_dump dut (
    .clock(clock), .reset(reset), .start(start),
    .dump_read_idx(dump_read_idx), .dump_read_data(dump_read_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;
  assign dump_read_data = regs[dump_read_idx];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_dump(input string tag, input int ready_pct, input int stall_idx,
                         input int poke_idx, input int abort_idx, input bit start_on_done);
    logic [4:0]  e_idx [33];
    logic [31:0] e_data [33];
    logic        e_last [33];
    logic [31:0] x = '0;
    int n_exp, beats = 0, dones = 0, stall_n = 0, post = 0;
    bit held = 0, fin = 0;
    logic [4:0]  h_idx;
    logic [31:0] h_data;
    logic        h_last;
    for (int k = 0; k < 32; k++) begin
      e_idx[k] = 5'(k);
      e_data[k] = regs[k];
      e_last[k] = (k == 31) && !CS;
      x ^= regs[k];
    end
    e_idx[32] = 5'd31;
    e_data[32] = x;
    e_last[32] = 1'b1;
    n_exp = CS ? 33 : 32;
    start = 1;
    out_ready = 0;
    tick;
    start = 0;
    chk({tag, " busy_after_start"}, busy, 1);
    chk({tag, " valid_in_load"}, out_valid, 0);
    chk({tag, " read_idx0"}, dump_read_idx, 0);
    tick;
    chk({tag, " latency_valid"}, out_valid, 1);
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      start = 0;
      if (out_valid && out_idx == 5'(stall_idx) && stall_n < 5) begin
        out_ready = 0;
        stall_n++;
      end else out_ready = ($urandom_range(99) < ready_pct);
      if (poke_idx >= 0 && out_valid && out_idx == 5'(poke_idx)) start = 1;
      if (start_on_done && done) start = 1;
      if (abort_idx >= 0 && out_valid && out_idx == 5'(abort_idx)) begin
        reset = 1;
        tick;
        reset = 0;
        chk({tag, " abort_valid"}, out_valid, 0);
        chk({tag, " abort_busy"}, busy, 0);
        chk({tag, " abort_done"}, done, 0);
        repeat (4) begin
          tick;
          chk({tag, " abort_no_done"}, done, 0);
        end
        return;
      end
      @(negedge clock);
      if (held) begin
        chk({tag, " hold_valid"}, out_valid, 1);
        chk({tag, " hold_idx"}, out_idx, h_idx);
        chk({tag, " hold_data"}, out_data, h_data);
        chk({tag, " hold_last"}, out_last, h_last);
      end
      if (out_valid && out_ready) begin
        if (beats < n_exp) begin
          chk({tag, " beat_idx"}, out_idx, e_idx[beats]);
          chk({tag, " beat_data"}, out_data, e_data[beats]);
          chk({tag, " beat_last"}, out_last, e_last[beats]);
          chk({tag, " beat_busy"}, busy, 1);
        end else chk({tag, " extra_beat"}, beats, n_exp);
        last_data = out_data;
        beats++;
      end
      held = out_valid && !out_ready;
      h_idx = out_idx;
      h_data = out_data;
      h_last = out_last;
      if (post > 0) begin
        chk({tag, " idle_after_done"}, {busy, out_valid, done}, 3'b000);
        post++;
        if (post > 3) fin = 1;
      end
      if (done && post == 0) begin
        dones++;
        chk({tag, " done_after_last"}, beats, n_exp);
        chk({tag, " busy_at_done"}, busy, 0);
        post = 1;
      end
      tick;
    end
    start = 0;
    out_ready = 0;
    chk({tag, " completed"}, fin, 1);
    chk({tag, " beat_count"}, beats, n_exp);
    chk({tag, " done_count"}, dones, 1);
    if (stall_idx >= 0) chk({tag, " stall_cycles"}, stall_n, 5);
  endtask

  initial begin
    reset = 1;
    start = 0;
    out_ready = 0;
    for (int k = 0; k < 32; k++) regs[k] = 32'(k) * 32'h01010101;
    tick;
    start = 1;
    tick;
    start = 0;
    chk("reset_valid", out_valid, 0);
    chk("reset_idx", out_idx, 0);
    chk("reset_data", out_data, 0);
    chk("reset_last", out_last, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_read_idx", dump_read_idx, 0);
    reset = 0;
    tick;
    chk("idle_busy", busy, 0);
    do_dump("pattern", 100, -1, -1, -1, 0);
    do_dump("stall7", 100, 7, -1, -1, 0);
    do_dump("poke10", 100, -1, 10, -1, 0);
    do_dump("abort15", 100, -1, -1, 15, 0);
    do_dump("after_abort", 100, -1, -1, -1, 0);
    do_dump("start_on_done", 100, -1, -1, -1, 1);
    do_dump("after_sod", 70, -1, -1, -1, 0);
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 32; k++) regs[k] = $urandom;
      do_dump("random", 60, -1, -1, -1, 0);
    end
`ifdef REGFILE_DUMP_CHECKSUM_EN
    regs[0] = '0;
    for (int k = 1; k < 32; k++) regs[k] = 32'hFFFFFFFF;
    do_dump("csum_ones", 100, -1, -1, -1, 0);
    chk("csum_ones_value", last_data, 32'hFFFFFFFF);
    for (int k = 0; k < 32; k++) regs[k] = '0;
    regs[1] = 32'h0000000F;
    regs[2] = 32'h000000F0;
    do_dump("csum_nibbles", 80, -1, -1, -1, 0);
    chk("csum_nibbles_value", last_data, 32'h000000FF);
`else
    chk("final_beat_value", last_data, regs[31]);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
